// File: rtl/adler32_chk_pkg.sv
// Shared definitions for the zlib Adler-32 verifier and its byte-step datapath.
package adler32_chk_pkg;

   localparam int unsigned DATA_WD = 32;
   localparam int unsigned SUM_WD  = 16;
   localparam int unsigned CNT_WD  = 3;
   localparam int unsigned IDX_WD  = 2;

   localparam logic [SUM_WD-1:0]  ADLER_MOD  = 16'd65521;
   localparam logic [DATA_WD-1:0] ADLER_INIT = 32'h0000_0001;

   // Running checksum laid out as the zlib trailer: {s2, s1}
   typedef struct packed {
      logic [SUM_WD-1:0] s2;
      logic [SUM_WD-1:0] s1;
   } adler_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RECV = 3'd1,
      PROC = 3'd2,
      TRL  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Byte idx 0 is the most significant byte of the word
   function automatic logic [7:0] word_byte(input logic [DATA_WD-1:0] word,
                                            input logic [IDX_WD-1:0]  idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/adler32_step.sv
// Combinational Adler-32 byte step: folds one byte into {s2,s1} using a single
// conditional subtract per sum, since both intermediate sums stay below 2*modulus.
module adler32_step
   import adler32_chk_pkg::*;
(
   input  adler_t     sum_i,
   input  logic [7:0] byte_i,
   output adler_t     sum_o
);

   localparam int unsigned EXT_WD = SUM_WD + 1;
   localparam logic [EXT_WD-1:0] MOD_X = {1'b0, ADLER_MOD};

   logic [EXT_WD-1:0] t1;
   logic [EXT_WD-1:0] t2;
   logic [SUM_WD-1:0] s1_n;
   logic [SUM_WD-1:0] s2_n;

   always_comb begin
      t1   = {1'b0, sum_i.s1} + EXT_WD'(byte_i);
      s1_n = (t1 >= MOD_X) ? SUM_WD'(t1 - MOD_X) : t1[SUM_WD-1:0];
      t2   = {1'b0, sum_i.s2} + {1'b0, s1_n};
      s2_n = (t2 >= MOD_X) ? SUM_WD'(t2 - MOD_X) : t2[SUM_WD-1:0];
      sum_o.s1 = s1_n;
      sum_o.s2 = s2_n;
   end

endmodule

// File: rtl/adler32_chk.sv
// Decode-side Adler-32 verifier: accepts inflated words, folds one byte per
// cycle, then compares the zlib trailer against the running checksum.
module adler32_chk
   import adler32_chk_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic               val_i,
   output logic               rdy_o,
   input  logic [DATA_WD-1:0] dat_i,
   input  logic               lst_i,
   input  logic [1:0]         lst_byt_i,
   input  logic               trl_val_i,
   output logic               trl_rdy_o,
   input  logic [DATA_WD-1:0] trl_i,
   output logic               done_o,
   output logic               ok_o,
   output logic [DATA_WD-1:0] dat_o
);

   state_t              state_q,   state_d;
   logic [DATA_WD-1:0]  word_q,    word_d;
   logic                lst_q,     lst_d;
   logic [CNT_WD-1:0]   cnt_q,     cnt_d;
   logic [IDX_WD-1:0]   idx_q,     idx_d;
   adler_t              sum_q,     sum_d;
   logic                ok_q,      ok_d;
   logic                done_q,    done_d;
   logic                rdy_q,     rdy_d;
   logic                trl_rdy_q, trl_rdy_d;

   adler_t              sum_step;
   logic                last_byte;

   adler32_step u_step (
      .sum_i  (sum_q),
      .byte_i (word_byte(word_q, idx_q)),
      .sum_o  (sum_step)
   );

   assign last_byte = ({1'b0, idx_q} == (cnt_q - 3'd1));

   // Next-state and datapath updates; start_i overrides every handshake
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      lst_d   = lst_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      ok_d    = ok_q;
      done_d  = 1'b0;

      if (start_i) begin
         state_d = RECV;
         word_d  = '0;
         lst_d   = 1'b0;
         cnt_d   = '0;
         idx_d   = '0;
         sum_d   = ADLER_INIT;
         ok_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            RECV: begin
               if (val_i) begin
                  word_d  = dat_i;
                  lst_d   = lst_i;
                  cnt_d   = lst_i ? (CNT_WD'(lst_byt_i) + 3'd1) : 3'd4;
                  idx_d   = '0;
                  state_d = PROC;
               end
            end
            PROC: begin
               sum_d = sum_step;
               if (last_byte) begin
                  state_d = lst_q ? TRL : RECV;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            TRL: begin
               if (trl_val_i) begin
                  ok_d    = (trl_i == sum_q);
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end

      rdy_d     = (state_d == RECV);
      trl_rdy_d = (state_d == TRL);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         word_q    <= '0;
         lst_q     <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
         sum_q     <= ADLER_INIT;
         ok_q      <= 1'b0;
         done_q    <= 1'b0;
         rdy_q     <= 1'b0;
         trl_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         lst_q     <= lst_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sum_q     <= sum_d;
         ok_q      <= ok_d;
         done_q    <= done_d;
         rdy_q     <= rdy_d;
         trl_rdy_q <= trl_rdy_d;
      end
   end

   assign rdy_o     = rdy_q;
   assign trl_rdy_o = trl_rdy_q;
   assign done_o    = done_q;
   assign ok_o      = ok_q;
   assign dat_o     = sum_q;

endmodule

// File: tb/tb_adler32_chk.sv
// Self-checking bench for adler32_chk: directed zlib vectors plus random streams
// compared against a modulo-arithmetic Adler-32 reference.
module tb_adler32_chk;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i;
   logic        val_i;
   logic        rdy_o;
   logic [31:0] dat_i;
   logic        lst_i;
   logic [1:0]  lst_byt_i;
   logic        trl_val_i;
   logic        trl_rdy_o;
   logic [31:0] trl_i;
   logic        done_o;
   logic        ok_o;
   logic [31:0] dat_o;

   int n_chk  = 0;
   int n_pass = 0;

   typedef logic [7:0] bq_t[$];

   adler32_chk dut (
      .clk       (clk),
      .rstn      (rstn),
      .start_i   (start_i),
      .val_i     (val_i),
      .rdy_o     (rdy_o),
      .dat_i     (dat_i),
      .lst_i     (lst_i),
      .lst_byt_i (lst_byt_i),
      .trl_val_i (trl_val_i),
      .trl_rdy_o (trl_rdy_o),
      .trl_i     (trl_i),
      .done_o    (done_o),
      .ok_o      (ok_o),
      .dat_o     (dat_o)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference Adler-32 straight from its definition
   function automatic logic [31:0] adler_ref(input bq_t b);
      int unsigned a = 1;
      int unsigned s = 0;
      foreach (b[i]) begin
         a = (a + 32'(b[i])) % 65521;
         s = (s + a) % 65521;
      end
      return {s[15:0], a[15:0]};
   endfunction

   function automatic bq_t words_to_bytes(input logic [31:0] w[$], input int nbytes);
      bq_t q;
      for (int i = 0; i < nbytes; i++) begin
         logic [31:0] cur;
         cur = w[i / 4];
         q.push_back(cur[31 - 8 * (i % 4) -: 8]);
      end
      return q;
   endfunction

   task automatic do_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Waits for rdy_o and hands over every word of the stream
   task automatic send_stream(input string tag, input bq_t bq);
      int n;
      int nw;
      n  = bq.size();
      nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         logic [31:0] word;
         int nb;
         int gap;
         word = '0;
         nb   = (n - 4 * w > 4) ? 4 : n - 4 * w;
         for (int k = 0; k < nb; k++) word[31 - 8 * k -: 8] = bq[4 * w + k];
         gap = 0;
         while (rdy_o !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
         end
         if (rdy_o !== 1'b1) begin
            check({tag, "_rdy_timeout"}, 32'(rdy_o), 32'd1);
            return;
         end
         if (w > 0) check({tag, "_gap"}, 32'(gap), 32'd4);
         val_i     = 1'b1;
         dat_i     = word;
         lst_i     = (w == nw - 1);
         lst_byt_i = 2'(nb - 1);
         @(negedge clk);
         val_i = 1'b0;
         lst_i = 1'b0;
      end
   endtask

   task automatic wait_trl(input string tag, output bit got);
      int t;
      t = 0;
      while (trl_rdy_o !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      got = (trl_rdy_o === 1'b1);
      if (!got) check({tag, "_trl_timeout"}, 32'(trl_rdy_o), 32'd1);
   endtask

   // Presents the trailer and checks the done pulse and verdict
   task automatic finish_stream(input string tag, input logic [31:0] trl, input logic [31:0] expsum);
      bit got;
      wait_trl(tag, got);
      if (!got) return;
      check({tag, "_sum"}, dat_o, expsum);
      check({tag, "_rdy_excl"}, 32'(rdy_o), 32'd0);
      trl_val_i = 1'b1;
      trl_i     = trl;
      @(negedge clk);
      trl_val_i = 1'b0;
      check({tag, "_done"}, 32'(done_o), 32'd1);
      check({tag, "_ok"}, 32'(ok_o), 32'(trl == expsum));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
      check({tag, "_ok_hold"}, 32'(ok_o), 32'(trl == expsum));
      check({tag, "_sum_hold"}, dat_o, expsum);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rdy"}, 32'(rdy_o), 32'd0);
      check({tag, "_trl_rdy"}, 32'(trl_rdy_o), 32'd0);
      check({tag, "_done"}, 32'(done_o), 32'd0);
      check({tag, "_ok"}, 32'(ok_o), 32'd0);
      check({tag, "_dat"}, dat_o, 32'h0000_0001);
   endtask

   initial begin
      logic [31:0] wq[$];
      bq_t abc;
      bq_t wiki;
      bq_t ffs;
      bq_t rq;
      logic [31:0] exp_sum;
      logic [31:0] trl;
      bit got;

      rstn = 1'b0; start_i = 1'b0; val_i = 1'b0; dat_i = '0; lst_i = 1'b0;
      lst_byt_i = '0; trl_val_i = 1'b0; trl_i = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rstn = 1'b1;
      val_i = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_rdy", 32'(rdy_o), 32'd0);
      val_i = 1'b0;

      wq = '{32'h6162_6300};
      abc = words_to_bytes(wq, 3);
      wq = '{32'h5769_6B69, 32'h7065_6469, 32'h6100_0000};
      wiki = words_to_bytes(wq, 9);

      // abc
      do_start();
      check("abc_start_rdy", 32'(rdy_o), 32'd1);
      check("abc_start_dat", dat_o, 32'h0000_0001);
      send_stream("abc", abc);
      finish_stream("abc", 32'h024D_0127, adler_ref(abc));
      check("abc_const", dat_o, 32'h024D_0127);

      // Wikipedia
      do_start();
      send_stream("wiki", wiki);
      finish_stream("wiki", 32'h11E6_0398, adler_ref(wiki));
      check("wiki_const", dat_o, 32'h11E6_0398);

      // abc with a bad trailer
      do_start();
      check("bad_ok_cleared", 32'(ok_o), 32'd0);
      send_stream("abc_bad", abc);
      finish_stream("abc_bad", 32'h024D_0128, adler_ref(abc));

      // 257 bytes of 0xFF exercise the modular wrap
      ffs = {};
      for (int i = 0; i < 257; i++) ffs.push_back(8'hFF);
      do_start();
      send_stream("wrap", ffs);
      exp_sum = adler_ref(ffs);
      finish_stream("wrap", exp_sum, exp_sum);
      check("wrap_s1", 32'(dat_o[15:0]), 32'h0000_000F);

      // start mid-PROC of the second Wikipedia word, with val_i held
      do_start();
      rq = wiki[0:7];
      send_stream("abort", rq);
      @(negedge clk);
      check("abort_in_proc", 32'(rdy_o), 32'd0);
      val_i = 1'b1; dat_i = 32'h6162_6300; lst_i = 1'b1; lst_byt_i = 2'd2;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; val_i = 1'b0; lst_i = 1'b0;
      check("abort_recv", 32'(rdy_o), 32'd1);
      check("abort_sum_clr", dat_o, 32'h0000_0001);
      // start wins over val_i while already waiting for a word
      val_i = 1'b1; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; val_i = 1'b0;
      check("start_wins_val", 32'(rdy_o), 32'd1);
      send_stream("replay", abc);
      finish_stream("replay", 32'h024D_0127, adler_ref(abc));

      // start wins over a simultaneous trailer
      do_start();
      send_stream("trlwin", abc);
      wait_trl("trlwin", got);
      trl_val_i = 1'b1; trl_i = 32'h024D_0127; start_i = 1'b1;
      @(negedge clk);
      trl_val_i = 1'b0; start_i = 1'b0;
      check("trlwin_done", 32'(done_o), 32'd0);
      check("trlwin_rdy", 32'(rdy_o), 32'd1);
      check("trlwin_trl_rdy", 32'(trl_rdy_o), 32'd0);
      check("trlwin_dat", dat_o, 32'h0000_0001);

      // reset while waiting for the trailer
      send_stream("rst", abc);
      wait_trl("rst", got);
      #2 rstn = 1'b0;
      #1 check_reset_vals("rst_async");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_idle");
      do_start();
      send_stream("post_rst", abc);
      finish_stream("post_rst", 32'h024D_0127, adler_ref(abc));

      // random streams against the reference
      for (int r = 0; r < 10; r++) begin
         int len;
         len = $urandom_range(1, 40);
         rq = {};
         for (int i = 0; i < len; i++) rq.push_back(8'($urandom_range(0, 255)));
         exp_sum = adler_ref(rq);
         trl = exp_sum;
         if (r % 2 == 1) trl = exp_sum ^ (32'd1 << $urandom_range(0, 31));
         do_start();
         send_stream($sformatf("rnd%0d", r), rq);
         finish_stream($sformatf("rnd%0d", r), trl, exp_sum);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
